// File: rtl/game_pkg.sv
// Shared game-level encodings for the scroll scheduler and the pixel generators.
package game_pkg;

  typedef enum logic [1:0] {
    GAME_INIT  = 2'd0,
    GAME_START = 2'd1,
    GAME_END   = 2'd2,
    GAME_RESET = 2'd3
  } game_state_t;

  // Width of the background image, which is also the xpos reload value.
  localparam int unsigned BG_WIDTH_DEFAULT = 1187;

endpackage

// File: rtl/scroll_sched_tick_divider.sv
// Programmable-period tick divider: counts while enabled and flags the last
// cycle of each period. The period is captured only when the count reloads,
// so a period change never stretches or truncates a period already running.
module tick_divider #(
  parameter int W = 19
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] period,
  output logic         tick
);

  logic [W-1:0] div_cnt;
  logic [W-1:0] period_q;
  logic         wrap;

  assign wrap = (div_cnt == period_q - W'(1));
  assign tick = en && wrap;

  // Count while enabled; hold at zero and keep tracking period while disabled.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt  <= '0;
      period_q <= '0;
    end else if (!en || wrap) begin
      div_cnt  <= '0;
      period_q <= period;
    end else begin
      div_cnt  <= div_cnt + W'(1);
    end
  end

endmodule

// File: rtl/scroll_sched.sv
// Game-level sequencer: game_state FSM, scroll tick, background x position,
// score and speed level. Speed rises one level every LEVEL_STEPS scroll steps.
module scroll_sched
  import game_pkg::*;
#(
  parameter int unsigned TICK_DIV_INIT = 500000,
  parameter int unsigned TICK_DIV_MIN  = 150000,
  parameter int unsigned SPEED_STEP    = 25000,
  parameter int unsigned LEVEL_STEPS   = 512,
  parameter int unsigned RESET_HOLD    = 16,
  parameter int unsigned BG_WIDTH      = BG_WIDTH_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_btn,
  input  logic        collision,
  output logic [1:0]  game_state,
  output logic        scroll_tick,
  output logic [10:0] xpos,
  output logic [15:0] score,
  output logic [3:0]  level
);

  localparam int PER_W  = $clog2(TICK_DIV_INIT + 1);
  localparam int HOLD_W = (RESET_HOLD > 1) ? $clog2(RESET_HOLD) : 1;
  localparam int STEP_W = (LEVEL_STEPS > 1) ? $clog2(LEVEL_STEPS) : 1;

  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RESET_HOLD - 1);
  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(LEVEL_STEPS - 1);
  localparam logic [10:0]       XPOS_LOAD = 11'(BG_WIDTH);

  game_state_t       state;
  game_state_t       state_next;
  logic [HOLD_W-1:0] hold_cnt;
  logic [STEP_W-1:0] step_cnt;
  logic [PER_W-1:0]  period;
  logic              div_tick;
  logic              tick_fire;
  logic              run_clear;

  // Scroll period for a level: shrinks by SPEED_STEP per level without
  // wrapping below zero, then clamped to the fastest allowed period.
  function automatic logic [PER_W-1:0] calc_period(input logic [3:0] lvl);
    logic [31:0] red;
    logic [31:0] base;
    red  = 32'(lvl) * SPEED_STEP;
    base = (red >= TICK_DIV_INIT) ? 32'd0 : (TICK_DIV_INIT - red);
    if (base < TICK_DIV_MIN) base = TICK_DIV_MIN;
    return base[PER_W-1:0];
  endfunction

  assign period = calc_period(level);

  tick_divider #(
    .W(PER_W)
  ) u_div (
    .clk    (clk),
    .rst    (rst),
    .en     (state == GAME_START),
    .period (period),
    .tick   (div_tick)
  );

  // A collision on the cycle a step is due wins: the step is dropped.
  assign tick_fire = (state == GAME_START) && div_tick && !collision;
  assign run_clear = (state == GAME_END) && start_btn;

  // State register and RESET-hold counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= GAME_INIT;
      hold_cnt <= '0;
    end else begin
      state    <= state_next;
      hold_cnt <= (state == GAME_RESET) ? hold_cnt + HOLD_W'(1) : '0;
    end
  end

  // Next-state logic; inputs that do not apply to a state are ignored there.
  always_comb begin
    state_next = state;
    case (state)
      GAME_INIT:  if (start_btn)              state_next = GAME_START;
      GAME_START: if (collision)              state_next = GAME_END;
      GAME_END:   if (start_btn)              state_next = GAME_RESET;
      GAME_RESET: if (hold_cnt == HOLD_LAST)  state_next = GAME_START;
      default:                                state_next = GAME_INIT;
    endcase
  end

  // Run-time registers: cleared on entry to RESET, advanced once per step.
  always_ff @(posedge clk) begin
    if (rst) begin
      scroll_tick <= 1'b0;
      xpos        <= XPOS_LOAD;
      score       <= '0;
      level       <= '0;
      step_cnt    <= '0;
    end else begin
      scroll_tick <= tick_fire;
      if (run_clear) begin
        xpos     <= XPOS_LOAD;
        score    <= '0;
        level    <= '0;
        step_cnt <= '0;
      end else if (tick_fire) begin
        xpos  <= (xpos == 11'd0) ? XPOS_LOAD : xpos - 11'd1;
        score <= (score == 16'hFFFF) ? score : score + 16'd1;
        if (step_cnt == STEP_LAST) begin
          step_cnt <= '0;
          level    <= (level == 4'hF) ? level : level + 4'd1;
        end else begin
          step_cnt <= step_cnt + STEP_W'(1);
        end
      end
    end
  end

  assign game_state = state;

endmodule

// File: tb/tb_scroll_sched.sv
// Self-checking bench for scroll_sched with a small, fast parameter set.
module tb_scroll_sched;

  localparam int P_INIT = 8;
  localparam int P_MIN  = 4;
  localparam int P_STEP = 2;
  localparam int L_STEP = 4;
  localparam int R_HOLD = 3;
  localparam int BGW    = 5;

  logic        clk;
  logic        rst;
  logic        start_btn;
  logic        collision;
  logic [1:0]  game_state;
  logic        scroll_tick;
  logic [10:0] xpos;
  logic [15:0] score;
  logic [3:0]  level;

  scroll_sched #(
    .TICK_DIV_INIT (P_INIT),
    .TICK_DIV_MIN  (P_MIN),
    .SPEED_STEP    (P_STEP),
    .LEVEL_STEPS   (L_STEP),
    .RESET_HOLD    (R_HOLD),
    .BG_WIDTH      (BGW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start_btn   (start_btn),
    .collision   (collision),
    .game_state  (game_state),
    .scroll_tick (scroll_tick),
    .xpos        (xpos),
    .score       (score),
    .level       (level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model state (owned by the negedge process only).
  int cyc = 0;
  bit armed = 0;
  int m_state, m_tick, m_xpos, m_score, m_level, m_steps, m_hold, m_next_due;
  int force_seq = 0;
  int force_seen = 0;

  // Observed ticks: edge number and the outputs right after each tick.
  int tick_cyc[$];
  int tick_xpos[$];
  int tick_score[$];
  int tick_level[$];

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s actual=timeout required=event (t=%0t)", name, $time);
  endtask

  function automatic int per(input int l);
    int b;
    b = (P_INIT > l * P_STEP) ? P_INIT - l * P_STEP : 0;
    return (b < P_MIN) ? P_MIN : b;
  endfunction

  // Advance the model by the posedge just past (inputs still hold their
  // sampled values here), then compare every output.
  always @(negedge clk) begin
    if (force_seq != force_seen) begin
      m_score = 16'hFFFE;
      force_seen = force_seq;
    end
    cyc++;
    if (rst) begin
      armed = 1; m_state = 0; m_tick = 0; m_xpos = BGW;
      m_score = 0; m_level = 0; m_steps = 0; m_hold = 0; m_next_due = 0;
    end else if (armed) begin
      m_tick = 0;
      case (m_state)
        0: if (start_btn) begin m_state = 1; m_next_due = cyc + per(m_level); end
        1: if (collision) m_state = 2;
           else if (cyc == m_next_due) begin
             m_tick = 1;
             m_next_due = cyc + per(m_level);
             m_xpos = (m_xpos == 0) ? BGW : m_xpos - 1;
             if (m_score != 16'hFFFF) m_score++;
             m_steps++;
             if (m_steps == L_STEP) begin
               m_steps = 0;
               if (m_level < 15) m_level++;
             end
           end
        2: if (start_btn) begin
             m_state = 3; m_hold = R_HOLD;
             m_xpos = BGW; m_score = 0; m_level = 0; m_steps = 0;
           end
        default: begin
          m_hold--;
          if (m_hold == 0) begin m_state = 1; m_next_due = cyc + per(0); end
        end
      endcase
    end
    if (armed) begin
      chk("state", game_state, m_state);
      chk("tick",  scroll_tick, m_tick);
      chk("xpos",  xpos, m_xpos);
      chk("score", score, m_score);
      chk("level", level, m_level);
    end
    if (scroll_tick) begin
      tick_cyc.push_back(cyc);
      tick_xpos.push_back(int'(xpos));
      tick_score.push_back(int'(score));
      tick_level.push_back(int'(level));
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic wait_ticks(input int target, input int budget, input string name);
    int b;
    b = 0;
    while (tick_cyc.size() < target && b < budget) begin
      step(1);
      b++;
    end
    if (tick_cyc.size() < target) fail_now(name);
  endtask

  task automatic pulse_start();
    start_btn = 1'b1;
    step(1);
    start_btn = 1'b0;
  endtask

  initial begin
    int base, start_edge, n, s0, nt;
    int xp_exp[6];
    xp_exp = '{4, 3, 2, 1, 0, 5};
    rst = 1'b1; start_btn = 1'b0; collision = 1'b0;
    step(3);
    rst = 1'b0;

    step(100);
    chk("idle_state", game_state, 0);
    chk("idle_xpos", xpos, 5);
    chk("idle_score", score, 0);
    chk("idle_level", level, 0);
    chk("idle_ticks", tick_cyc.size(), 0);

    collision = 1'b1;
    step(4);
    collision = 1'b0;
    step(1);
    chk("init_ignores_collision", game_state, 0);

    base = tick_cyc.size();
    start_edge = cyc + 1;
    pulse_start();
    chk("start_state", game_state, 1);
    step(2);
    pulse_start();
    chk("start_ignores_btn", game_state, 1);

    wait_ticks(base + 14, 400, "first_14_ticks");
    if (tick_cyc.size() >= base + 14) begin
      chk("first_tick_latency", tick_cyc[base] - start_edge, 8);
      for (int k = 0; k < 6; k++) chk("xpos_seq", tick_xpos[base + k], xp_exp[k]);
      chk("score_after_6", tick_score[base + 5], 6);
      chk("level_after_4", tick_level[base + 3], 1);
      chk("level_after_8", tick_level[base + 7], 2);
      chk("level_after_12", tick_level[base + 11], 3);
      chk("gap_4_5", tick_cyc[base + 4] - tick_cyc[base + 3], 8);
      chk("gap_5_6", tick_cyc[base + 5] - tick_cyc[base + 4], 6);
      chk("gap_8_9", tick_cyc[base + 8] - tick_cyc[base + 7], 6);
      chk("gap_9_10", tick_cyc[base + 9] - tick_cyc[base + 8], 4);
      chk("gap_13_14", tick_cyc[base + 13] - tick_cyc[base + 12], 4);
    end

    wait_ticks(base + 72, 1000, "level_sat_ticks");
    chk("level_sat", level, 15);

    // Collision exactly on a due step.
    n = 0;
    while (!(m_state == 1 && m_next_due == cyc + 1) && n < 100) begin
      step(1);
      n++;
    end
    if (n >= 100) fail_now("due_tick_search");
    s0 = int'(score);
    nt = tick_cyc.size();
    collision = 1'b1;
    step(1);
    collision = 1'b0;
    chk("coll_state", game_state, 2);
    chk("coll_no_tick", scroll_tick, 0);
    chk("coll_score", score, s0);
    step(10);
    chk("end_no_ticks", tick_cyc.size(), nt);
    chk("end_score_held", score, s0);

    pulse_start();
    for (int k = 0; k < 3; k++) begin
      chk("hold_state", game_state, 3);
      chk("hold_xpos", xpos, 5);
      chk("hold_score", score, 0);
      chk("hold_level", level, 0);
      step(1);
    end
    chk("after_hold_state", game_state, 1);

    // rst in the middle of a run.
    base = tick_cyc.size();
    wait_ticks(base + 7, 200, "seven_ticks");
    chk("score_seven", score, 7);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    chk("midrun_rst_state", game_state, 0);
    chk("midrun_rst_xpos", xpos, 5);
    chk("midrun_rst_score", score, 0);

    // rst in the middle of RESET.
    pulse_start();
    step(3);
    collision = 1'b1;
    step(1);
    collision = 1'b0;
    pulse_start();
    step(1);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    chk("midreset_rst_state", game_state, 0);

    // Score saturation.
    pulse_start();
    step(2);
    force dut.score = 16'hFFFE;
    #1;
    release dut.score;
    force_seq++;
    base = tick_cyc.size();
    wait_ticks(base + 3, 100, "sat_ticks");
    chk("score_sat", score, 16'hFFFF);

    // Random traffic against the model.
    for (int i = 0; i < 2500; i++) begin
      start_btn = ($urandom_range(0, 19) == 0);
      collision = ($urandom_range(0, 29) == 0);
      rst       = ($urandom_range(0, 399) == 0);
      step(1);
    end
    start_btn = 1'b0; collision = 1'b0; rst = 1'b0;
    step(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
